uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NREQ byte producers. It arbitrates requests round-robin, latches the winner's byte, and drives the transmitter's Send/Datain pair. It tracks the transmitter's busy line so each frame completes before the next grant. It sits between the producer blocks and the UART top level; it does not touch baud or parity configuration.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width presented to UART Datain
TIMEOUT, 255, Clock cycles allowed for UART busy to rise after Send (used only with the optional feature)

Ports:
Clock  input  1  system clock; all state changes on its rising edge
Rst  input  1  asynchronous active-high reset
Req  input  NREQ  level request per requester; held until granted
ReqData  input  NREQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
Grant  output  NREQ  one-hot, one-cycle pulse; byte of that requester latched
UartBusy  input  1  UART transmitter busy
Send  output  1  UART start request
Datain  output  DATA_W  byte to UART, stable while a frame is owned
Owner  output  3  index of current/last granted requester
Active  output  1  high from grant until UART busy falls
Error  output  1  one-cycle pulse on handshake timeout (optional feature only, else tied 0)

Behaviour:
- Reset (async, any state): FSM=IDLE; Grant=0, Send=0, Datain=0, Owner=0, Active=0, Error=0; round-robin pointer=0.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: if UartBusy=1, stay. Else if any Req bit is set, choose the first set bit searching from pointer upward, with wrap. In the same cycle, register Datain=ReqData[winner], Owner=winner, Grant[winner]=1 for one cycle, Active=1; go to LOAD.
- LOAD: Send=1; go to WAIT_BUSY.
- WAIT_BUSY: hold Send=1 until UartBusy=1 is sampled, then Send=0 and go to WAIT_DONE.
- WAIT_DONE: when UartBusy=0 is sampled, set Active=0, set pointer=(Owner+1) mod NREQ, and go to IDLE.
- Latency: Req rise in IDLE -> Grant next edge -> Send one edge later.
- Minimum spacing between grants: one IDLE cycle after busy falls.
- Datain is unchanged from grant until the next grant.
- Req and ReqData are sampled only in IDLE. Requester changes in other states are ignored.
- A requester must drop Req the cycle after its Grant pulse, or it re-arbitrates at lower priority after the others.
- Simultaneous requests: the pointer decides; the just-served requester has lowest priority next round.
- Arbitration uses only Req bits 0..NREQ-1. Owner is zero-extended.
- Reset mid-frame drops the byte; the UART handles its own reset.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With it defined: an 8-bit counter clears on entry to WAIT_BUSY and increments each cycle there. When it reaches TIMEOUT, the block drops Send, pulses Error for one cycle, clears Active, advances the pointer, and returns to IDLE. The byte is discarded.
- Without it: there is no counter, Error is tied 0, and WAIT_BUSY waits indefinitely.

Decomposition:
- Package uart_arb_pkg: state enum {IDLE, LOAD, WAIT_BUSY, WAIT_DONE}, the default NREQ and DATA_W constants, and the timeout counter width constant.
- One natural sub-module, rr_picker: combinational round-robin priority select. Inputs are req and pointer; outputs are a one-hot grant and a valid flag. It is reusable elsewhere.
- The FSM, data latch and timeout counter stay in uart_tx_arbiter.

Test Plan:
- Single request: Req=4'b0010, ReqData[15:8]=8'hA5, UartBusy rises 2 cycles after Send and falls 100 cycles later -> Grant=4'b0010 for 1 cycle, Datain=8'hA5, Send high exactly until busy sampled high, Active drops with busy, Owner=1.
- Contention: Req=4'b1111 held, pointer=0 -> grant order 0,1,2,3,0, one full frame each, no overlap of Active periods.
- Busy at entry: UartBusy=1 in IDLE with Req=4'b0001 -> no Grant until busy=0, then Grant next edge.
- Reset mid-frame: assert Rst during WAIT_DONE -> all outputs 0 immediately (asynchronous), pointer=0, next request arbitrated from index 0.
- Data stability: change ReqData while in WAIT_DONE -> Datain unchanged.
- Timeout (UART_ARB_TIMEOUT_EN defined, TIMEOUT=10): UartBusy held 0 after Send -> Error pulses on cycle 10 in WAIT_BUSY, Send=0, FSM back in IDLE. Without the macro: Send stays high and Error=0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int ARB_NREQ   = 4;
    localparam int ARB_DATA_W = 8;
    localparam int TO_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (oh[k[2:0]]) idx = k[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/UART-side signal bundle of the arbiter; master = producers and UART, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
);
    logic [NREQ-1:0]        Req;
    logic [NREQ*DATA_W-1:0] ReqData;
    logic [NREQ-1:0]        Grant;
    logic                   UartBusy;
    logic                   Send;
    logic [DATA_W-1:0]      Datain;
    logic [2:0]             Owner;
    logic                   Active;
    logic                   Error;

    modport master (
        output Req, ReqData, UartBusy,
        input  Grant, Send, Datain, Owner, Active, Error
    );

    modport slave (
        input  Req, ReqData, UartBusy,
        output Grant, Send, Datain, Owner, Active, Error
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or above the pointer, with wrap.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic            o_valid
);

    logic [NREQ-1:0] w_rot;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_rot   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_rot = i_req >> ((32'(i_ptr) + k) % NREQ);
            if (!o_valid && w_rot[0]) begin
                o_grant = NREQ'(1) << ((32'(i_ptr) + k) % NREQ);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte producers.
// Optional handshake timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic         Clock,
    input  logic         Rst,
    uart_tx_arbiter_if.slave bus
);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_e        r_state, w_state_nxt;
    logic [2:0]        r_ptr, w_ptr_nxt, w_ptr_adv;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic              r_send, w_send_nxt;
    logic [DATA_W-1:0] r_datain, w_datain_nxt;
    logic [2:0]        r_owner, w_owner_nxt;
    logic              r_active, w_active_nxt;

    logic [NREQ-1:0]   w_pick;
    logic              w_valid;
    logic [2:0]        w_pick_idx;
    logic [DATA_W-1:0] w_pick_data;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .i_req   (bus.Req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_valid (w_valid)
    );

    assign w_pick_idx  = oh2idx(8'(w_pick));
    assign w_pick_data = DATA_W'(bus.ReqData >> (32'(w_pick_idx) * DATA_W));
    assign w_ptr_adv   = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                r_error, w_error_nxt;
    assign w_cnt_inc = r_cnt + 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = '0;
        w_send_nxt   = r_send;
        w_datain_nxt = r_datain;
        w_owner_nxt  = r_owner;
        w_active_nxt = r_active;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
        w_error_nxt  = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (!bus.UartBusy && w_valid) begin
                    w_grant_nxt  = w_pick;
                    w_datain_nxt = w_pick_data;
                    w_owner_nxt  = w_pick_idx;
                    w_active_nxt = 1'b1;
                    w_state_nxt  = LOAD;
                end
            end
            LOAD: begin
                w_send_nxt  = 1'b1;
                w_state_nxt = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (bus.UartBusy) begin
                    w_send_nxt  = 1'b0;
                    w_state_nxt = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Busy wins over a simultaneous expiry; the byte is dropped on expiry.
                else if (w_cnt_inc == TO_CNT_W'(TIMEOUT)) begin
                    w_send_nxt   = 1'b0;
                    w_error_nxt  = 1'b1;
                    w_active_nxt = 1'b0;
                    w_ptr_nxt    = w_ptr_adv;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.UartBusy) begin
                    w_active_nxt = 1'b0;
                    w_ptr_nxt    = w_ptr_adv;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_send   <= 1'b0;
            r_datain <= '0;
            r_owner  <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_grant  <= w_grant_nxt;
            r_send   <= w_send_nxt;
            r_datain <= w_datain_nxt;
            r_owner  <= w_owner_nxt;
            r_active <= w_active_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_error <= w_error_nxt;
        end
    end
    assign bus.Error = r_error;
`else
    assign bus.Error = 1'b0;
`endif

    assign bus.Grant  = r_grant;
    assign bus.Send   = r_send;
    assign bus.Datain = r_datain;
    assign bus.Owner  = r_owner;
    assign bus.Active = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a round-robin reference model.
// Timeout expectations follow UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock (clk),
        .Rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Called in IDLE with UartBusy low and at least one request pending.
    task automatic run_frame(input int delay, input int len, input bit drop, input bit poke);
        int          w;
        logic [31:0] rd;
        logic [7:0]  d;
        w  = rr_pick(bus.Req, model_ptr);
        rd = bus.ReqData;
        d  = rd[w*8 +: 8];
        @(posedge clk); #1;
        check("grant", bus.Grant, 32'(1) << w);
        check("datain_at_grant", bus.Datain, d);
        check("owner", bus.Owner, w);
        check("active_rise", bus.Active, 1);
        check("send_not_yet", bus.Send, 0);
        if (drop) bus.Req[w] = 1'b0;
        @(posedge clk); #1;
        check("grant_pulse_end", bus.Grant, 0);
        check("send_rise", bus.Send, 1);
        for (int i = 1; i < delay; i++) begin
            @(posedge clk); #1;
            check("send_hold", bus.Send, 1);
        end
        bus.UartBusy = 1'b1;
        @(posedge clk); #1;
        check("send_fall", bus.Send, 0);
        if (poke) bus.ReqData = $urandom;
        for (int i = 1; i < len; i++) begin
            @(posedge clk); #1;
            check("active_busy", bus.Active, 1);
        end
        check("datain_stable", bus.Datain, d);
        bus.UartBusy = 1'b0;
        @(posedge clk); #1;
        check("active_fall", bus.Active, 0);
        check("no_early_grant", bus.Grant, 0);
        model_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int w;

        rst = 1'b1;
        bus.Req = '0;
        bus.ReqData = '0;
        bus.UartBusy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", bus.Grant, 0);
        check("rst_send", bus.Send, 0);
        check("rst_datain", bus.Datain, 0);
        check("rst_owner", bus.Owner, 0);
        check("rst_active", bus.Active, 0);
        check("rst_error", bus.Error, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_grant", bus.Grant, 0);

        // Contention with all requests held.
        model_ptr = 0;
        bus.Req = 4'b1111;
        bus.ReqData = $urandom;
        for (int i = 0; i < 5; i++) begin
            run_frame($urandom_range(1, 3), $urandom_range(1, 4), 1'b0, 1'b0);
            check("rr_order", bus.Owner, exp_order[i]);
        end
        bus.Req = '0;

        // Single request with a long busy period and data poked mid-frame.
        bus.Req = 4'b0010;
        bus.ReqData = 32'h1234_A5CD;
        run_frame(2, 100, 1'b1, 1'b1);
        check("single_owner", bus.Owner, 1);
        check("single_datain", bus.Datain, 8'hA5);

        // UART busy on entry blocks the grant.
        bus.UartBusy = 1'b1;
        bus.Req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("busy_entry_no_grant", bus.Grant, 0);
        end
        bus.UartBusy = 1'b0;
        run_frame(1, 3, 1'b1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 12; n++) begin
            bus.Req = 4'($urandom_range(1, 15)) | bus.Req;
            if ($urandom_range(0, 1) == 1) bus.ReqData = $urandom;
            run_frame($urandom_range(1, 4), $urandom_range(1, 6),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while the frame is in WAIT_DONE.
        bus.Req = 4'b0010;
        @(posedge clk); #1;
        bus.Req = '0;
        @(posedge clk); #1;
        bus.UartBusy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_active", bus.Active, 1);
        #3 rst = 1'b1;
        #1;
        check("arst_grant", bus.Grant, 0);
        check("arst_send", bus.Send, 0);
        check("arst_datain", bus.Datain, 0);
        check("arst_owner", bus.Owner, 0);
        check("arst_active", bus.Active, 0);
        check("arst_error", bus.Error, 0);
        bus.UartBusy = 1'b0;
        #2 rst = 1'b0;
        model_ptr = 0;
        bus.Req = 4'b1001;
        run_frame(1, 2, 1'b1, 1'b0);
        check("post_rst_owner", bus.Owner, 0);
        bus.Req = '0;

        // UART never acknowledges Send.
        bus.Req = 4'b0100;
        bus.ReqData = $urandom;
        w = rr_pick(bus.Req, model_ptr);
        @(posedge clk); #1;
        check("to_grant", bus.Grant, 32'(1) << w);
        bus.Req = '0;
        @(posedge clk); #1;
        check("to_send_rise", bus.Send, 1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT; i++) begin
            @(posedge clk); #1;
            check("to_send_hold", bus.Send, 1);
            check("to_no_error", bus.Error, 0);
        end
        @(posedge clk); #1;
        check("to_error", bus.Error, 1);
        check("to_send_drop", bus.Send, 0);
        check("to_active_drop", bus.Active, 0);
        @(posedge clk); #1;
        check("to_error_pulse", bus.Error, 0);
        model_ptr = (w + 1) % NREQ;
`else
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            @(posedge clk); #1;
            check("nto_send_hold", bus.Send, 1);
            check("nto_error", bus.Error, 0);
        end
        bus.UartBusy = 1'b1;
        @(posedge clk); #1;
        check("nto_send_fall", bus.Send, 0);
        bus.UartBusy = 1'b0;
        @(posedge clk); #1;
        check("nto_active_fall", bus.Active, 0);
        model_ptr = (w + 1) % NREQ;
`endif

        // Pointer has moved past the last owner.
        bus.Req = 4'b1111;
        bus.ReqData = $urandom;
        run_frame(1, 2, 1'b1, 1'b0);
        check("final_owner", bus.Owner, (w + 1) % NREQ);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
